// File: rtl/barcode_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | barcode_pkg : shared types and helpers for the barcode locator    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package barcode_pkg;

  localparam int COORD_W = 10;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_IN_SEG = 2'd2,
    ST_DONE   = 2'd3
  } line_state_e;

  // True on the first registered sample that reaches the active sync level.
  function automatic logic vs_rise(input logic cur, input logic prev, input logic active);
    return (cur == active) && (prev != active);
  endfunction

  // |a-b| <= tol without wrap: subtract the smaller from the larger.
  function automatic logic edge_close(input coord_t a, input coord_t b, input coord_t tol);
    coord_t d;
    d = (a >= b) ? (a - b) : (b - a);
    return d <= tol;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bar_stability_filter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bar_stability_filter : frame-to-frame lock / loss of bar edges    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module bar_stability_filter
  import barcode_pkg::*;
#(
  parameter int TOL           = 4,
  parameter int STABLE_FRAMES = 3,
  parameter int LOST_FRAMES   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_commit,
  input  logic               i_cand_valid,
  input  logic [COORD_W-1:0] i_cand_l,
  input  logic [COORD_W-1:0] i_cand_r,
  output logic [COORD_W-1:0] o_bar_left,
  output logic [COORD_W-1:0] o_bar_right,
  output logic               o_bar_valid,
  output logic               o_frame_done
);

  localparam int STABLE_W = $clog2(STABLE_FRAMES + 1);
  localparam int LOST_W   = $clog2(LOST_FRAMES + 1);
  localparam logic [STABLE_W-1:0] c_stable_max = STABLE_W'(STABLE_FRAMES);
  localparam logic [STABLE_W-1:0] c_stable_one = STABLE_W'(1);
  localparam logic [LOST_W-1:0]   c_lost_max   = LOST_W'(LOST_FRAMES);
  localparam logic [LOST_W-1:0]   c_lost_one   = LOST_W'(1);
  localparam coord_t              c_tol        = coord_t'(TOL);

  logic [STABLE_W-1:0] r_stable;
  logic [LOST_W-1:0]   r_lost;
  logic [COORD_W-1:0]  r_prev_l;
  logic [COORD_W-1:0]  r_prev_r;

  logic                w_match;
  logic [STABLE_W-1:0] w_stable_next;
  logic [LOST_W-1:0]   w_lost_next;

  assign w_match       = edge_close(i_cand_l, r_prev_l, c_tol) && edge_close(i_cand_r, r_prev_r, c_tol);
  assign w_stable_next = !w_match ? c_stable_one :
                         (r_stable == c_stable_max) ? r_stable : r_stable + c_stable_one;
  assign w_lost_next   = (r_lost == c_lost_max) ? r_lost : r_lost + c_lost_one;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable     <= '0;
      r_lost       <= '0;
      r_prev_l     <= '0;
      r_prev_r     <= '0;
      o_bar_left   <= '0;
      o_bar_right  <= '0;
      o_bar_valid  <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= i_commit;
      if (i_commit) begin
        if (i_cand_valid) begin
          r_stable <= w_stable_next;
          r_lost   <= '0;
          r_prev_l <= i_cand_l;
          r_prev_r <= i_cand_r;
          // Load only on the frame that completes the streak, so small
          // jitter after lock does not move the marker.
          if ((w_stable_next == c_stable_max) && (r_stable != c_stable_max)) begin
            o_bar_left  <= i_cand_l;
            o_bar_right <= i_cand_r;
            o_bar_valid <= 1'b1;
          end
        end else begin
          r_stable <= '0;
          r_lost   <= w_lost_next;
          if (w_lost_next == c_lost_max) begin
            o_bar_left  <= '0;
            o_bar_right <= '0;
            o_bar_valid <= 1'b0;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/barcode_locator.sv
`default_nettype none
// +------------------------------------------------------------------+
// | barcode_locator : widest bar run on the scan line, frame-filtered |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module barcode_locator
  import barcode_pkg::*;
#(
  parameter int   SCAN_Y        = 122,
  parameter int   MAX_GAP       = 40,
  parameter int   MIN_WIDTH     = 100,
  parameter int   TOL           = 4,
  parameter int   STABLE_FRAMES = 3,
  parameter int   LOST_FRAMES   = 8,
  parameter logic VS_ACTIVE     = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COORD_W-1:0] x_in,
  input  logic [COORD_W-1:0] y_in,
  input  logic               in_de,
  input  logic               in_vs,
  input  logic               in_data,
  output logic [COORD_W-1:0] bar_left,
  output logic [COORD_W-1:0] bar_right,
  output logic               bar_valid,
  output logic               frame_done
);

  localparam int GAP_W = $clog2(MAX_GAP + 2);
  localparam logic [GAP_W-1:0] c_gap_split = GAP_W'(MAX_GAP + 1);
  localparam logic [GAP_W-1:0] c_gap_one   = GAP_W'(1);
  localparam coord_t           c_scan_y    = coord_t'(SCAN_Y);
  localparam coord_t           c_min_width = coord_t'(MIN_WIDTH);

  line_state_e        r_state;
  logic [COORD_W-1:0] r_seg_l;
  logic [COORD_W-1:0] r_seg_r;
  logic [COORD_W-1:0] r_best_l;
  logic [COORD_W-1:0] r_best_r;
  logic               r_best_vld;
  logic [GAP_W-1:0]   r_gap;
  logic               r_vs;
  logic               r_vs_d;
  logic               r_de_d;

  logic               w_commit;
  logic               w_vs_now;
  logic               w_line_start;
  logic               w_line_end;
  logic               w_seg_wins;
  logic               w_cand_valid;
  logic [GAP_W-1:0]   w_gap_next;

  assign w_commit     = vs_rise(r_vs, r_vs_d, VS_ACTIVE);
  assign w_vs_now     = (in_vs == VS_ACTIVE);
  // r_de_d resets high so a line already in progress at reset release is ignored.
  assign w_line_start = in_de && !r_de_d && (y_in == c_scan_y);
  assign w_line_end   = w_vs_now || !in_de;
  assign w_seg_wins   = !r_best_vld || ((r_seg_r - r_seg_l) > (r_best_r - r_best_l));
  assign w_gap_next   = r_gap + c_gap_one;
  assign w_cand_valid = (r_state == ST_DONE) && r_best_vld &&
                        ((r_best_r - r_best_l) >= c_min_width);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_seg_l    <= '0;
      r_seg_r    <= '0;
      r_best_l   <= '0;
      r_best_r   <= '0;
      r_best_vld <= 1'b0;
      r_gap      <= '0;
      r_vs       <= ~VS_ACTIVE;
      r_vs_d     <= ~VS_ACTIVE;
      r_de_d     <= 1'b1;
    end else begin
      r_vs   <= in_vs;
      r_vs_d <= r_vs;
      r_de_d <= in_de;
      if (w_commit) begin
        r_state    <= ST_IDLE;
        r_best_l   <= '0;
        r_best_r   <= '0;
        r_best_vld <= 1'b0;
        r_gap      <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_line_start && !w_vs_now) begin
              if (in_data) begin
                r_state <= ST_IN_SEG;
                r_seg_l <= x_in;
                r_seg_r <= x_in;
                r_gap   <= '0;
              end else begin
                r_state <= ST_SEARCH;
              end
            end
          end
          ST_SEARCH: begin
            if (w_line_end) begin
              r_state <= ST_DONE;
            end else if (in_data) begin
              r_state <= ST_IN_SEG;
              r_seg_l <= x_in;
              r_seg_r <= x_in;
              r_gap   <= '0;
            end
          end
          ST_IN_SEG: begin
            // Line end, sync truncation and an over-long gap all close the
            // segment at its last black pixel.
            if (w_line_end || (!in_data && (w_gap_next == c_gap_split))) begin
              if (w_seg_wins) begin
                r_best_l   <= r_seg_l;
                r_best_r   <= r_seg_r;
                r_best_vld <= 1'b1;
              end
              r_state <= w_line_end ? ST_DONE : ST_SEARCH;
              r_gap   <= w_line_end ? r_gap : w_gap_next;
            end else if (in_data) begin
              r_seg_r <= x_in;
              r_gap   <= '0;
            end else begin
              r_gap <= w_gap_next;
            end
          end
          default: begin
            r_state <= r_state;
          end
        endcase
      end
    end
  end

  bar_stability_filter #(
    .TOL          (TOL),
    .STABLE_FRAMES(STABLE_FRAMES),
    .LOST_FRAMES  (LOST_FRAMES)
  ) u_filter (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_commit    (w_commit),
    .i_cand_valid(w_cand_valid),
    .i_cand_l    (r_best_l),
    .i_cand_r    (r_best_r),
    .o_bar_left  (bar_left),
    .o_bar_right (bar_right),
    .o_bar_valid (bar_valid),
    .o_frame_done(frame_done)
  );

endmodule
`default_nettype wire

// File: tb/tb_barcode_locator.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_barcode_locator : directed table plus randomized frames         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_barcode_locator;

  localparam int W         = 480;
  localparam int MAX_GAP   = 40;
  localparam int MIN_WIDTH = 100;
  localparam int TOL       = 4;
  localparam int STABLE    = 3;
  localparam int LOST      = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] x_in;
  logic [9:0] y_in;
  logic       in_de;
  logic       in_vs;
  logic       in_data;
  logic [9:0] bar_left;
  logic [9:0] bar_right;
  logic       bar_valid;
  logic       frame_done;

  always #5 clk = ~clk;

  barcode_locator #(
    .SCAN_Y(122), .MAX_GAP(MAX_GAP), .MIN_WIDTH(MIN_WIDTH), .TOL(TOL),
    .STABLE_FRAMES(STABLE), .LOST_FRAMES(LOST), .VS_ACTIVE(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .x_in(x_in), .y_in(y_in), .in_de(in_de),
    .in_vs(in_vs), .in_data(in_data), .bar_left(bar_left), .bar_right(bar_right),
    .bar_valid(bar_valid), .frame_done(frame_done)
  );

  int total = 0;
  int bad   = 0;
  bit pix[W];

  // Reference model state: committed outputs plus streak bookkeeping.
  int m_left, m_right, m_stable, m_lost, m_prev_l, m_prev_r;
  bit m_valid;

  typedef struct {
    int a_l; int a_r; int b_l; int b_r; int hole; int trunc; bit skip;
    int e_l; int e_r; bit e_v;
  } vec_t;
  vec_t tbl[35];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void clear_line();
    foreach (pix[i]) pix[i] = 1'b0;
  endfunction

  function automatic void paint(input int l, input int r, input bit v);
    for (int x = (l < 0 ? 0 : l); x <= (r > W-1 ? W-1 : r); x++) pix[x] = v;
  endfunction

  // Widest group of black pixels whose internal white runs are <= MAX_GAP.
  function automatic void ref_cand(input int lim, output bit v, output int l, output int r);
    int bl, br, cl, cr;
    bl = -1; br = -1; cl = -1; cr = -1;
    for (int x = 0; x < lim; x++) begin
      if (pix[x]) begin
        if (cl >= 0 && (x - cr - 1) > MAX_GAP) begin
          if (bl < 0 || (cr - cl) > (br - bl)) begin bl = cl; br = cr; end
          cl = -1;
        end
        if (cl < 0) cl = x;
        cr = x;
      end
    end
    if (cl >= 0 && (bl < 0 || (cr - cl) > (br - bl))) begin bl = cl; br = cr; end
    v = (bl >= 0) && ((br - bl) >= MIN_WIDTH);
    l = bl;
    r = br;
  endfunction

  function automatic void model_reset();
    m_left = 0; m_right = 0; m_valid = 0; m_stable = 0; m_lost = 0; m_prev_l = 0; m_prev_r = 0;
  endfunction

  function automatic void model_commit(input bit v, input int l, input int r);
    int dl, dr, ns;
    if (v) begin
      dl = (l > m_prev_l) ? l - m_prev_l : m_prev_l - l;
      dr = (r > m_prev_r) ? r - m_prev_r : m_prev_r - r;
      ns = (dl <= TOL && dr <= TOL) ? ((m_stable + 1 > STABLE) ? STABLE : m_stable + 1) : 1;
      if (ns == STABLE && m_stable != STABLE) begin m_left = l; m_right = r; m_valid = 1; end
      m_stable = ns; m_prev_l = l; m_prev_r = r; m_lost = 0;
    end else begin
      m_stable = 0;
      if (m_lost < LOST) m_lost++;
      if (m_lost == LOST) begin m_left = 0; m_right = 0; m_valid = 0; end
    end
  endfunction

  // One frame: decoy line 120, scan line 122 from pix[], then vertical sync.
  task automatic run_frame(input int trunc, input int rst_x, input bit skip);
    bit v;
    int cl, cr;
    bit line_ok;
    line_ok = !skip && (rst_x < 0);
    y_in = 10'd120;
    for (int x = 0; x < 8; x++) begin
      x_in = 10'(x); in_de = 1'b1; in_data = 1'b1; step();
    end
    in_de = 1'b0; in_data = 1'b0;
    repeat (4) step();
    if (!skip) begin
      y_in = 10'd122;
      for (int x = 0; x < W; x++) begin
        if (x == trunc) break;
        x_in = 10'(x); in_de = 1'b1; in_data = pix[x];
        if (x == rst_x) begin
          rst_n = 1'b0;
          #1;
          check("rst_async_left", bar_left, 0);
          check("rst_async_right", bar_right, 0);
          check("rst_async_valid", bar_valid, 0);
          check("rst_async_fd", frame_done, 0);
          model_reset();
        end
        if (rst_x >= 0 && x == rst_x + 3) rst_n = 1'b1;
        step();
      end
    end
    if (trunc >= 0) begin
      x_in = 10'(trunc); in_de = 1'b1; in_data = 1'b1;
    end else begin
      in_de = 1'b0; in_data = 1'b0;
      repeat (4) step();
      y_in = 10'd123;
    end
    in_vs = 1'b0;
    step();
    in_de = 1'b0; in_data = 1'b0;
    check("fd_latency", frame_done, 0);
    ref_cand((trunc >= 0) ? trunc : W, v, cl, cr);
    if (!line_ok) v = 1'b0;
    model_commit(v, cl, cr);
    step();
    check("fd_pulse", frame_done, 1);
    check("model_left", bar_left, m_left);
    check("model_right", bar_right, m_right);
    check("model_valid", bar_valid, m_valid);
    step();
    check("fd_single", frame_done, 0);
    in_vs = 1'b1;
    repeat (2) step();
  endtask

  function automatic void row(input int i, input int al, input int ar, input int bl, input int br,
                              input int hole, input int trunc, input bit skip,
                              input int el, input int er, input bit ev);
    tbl[i] = '{al, ar, bl, br, hole, trunc, skip, el, er, ev};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bl, br, reps, kind, j, jl, jr, mid, hl, trunc;
    bit skip;

    row(0, 150, 330, -1, -1, 20, -1, 0, 0, 0, 0);
    row(1, 150, 330, -1, -1, 20, -1, 0, 0, 0, 0);
    row(2, 150, 330, -1, -1, 20, -1, 0, 150, 330, 1);
    row(3, 152, 333, -1, -1, 20, -1, 0, 150, 330, 1);
    for (int i = 4; i < 7; i++) row(i, 170, 350, -1, -1, 10, -1, 0, 150, 330, 1);
    tbl[6].e_l = 170; tbl[6].e_r = 350;
    for (int i = 7; i < 10; i++) row(i, 50, 120, 200, 400, 0, -1, 0, 170, 350, 1);
    tbl[9].e_l = 200; tbl[9].e_r = 400;
    for (int i = 10; i < 13; i++) row(i, 50, 120, 161, 400, 0, -1, 0, 200, 400, 1);
    tbl[12].e_l = 50;
    for (int i = 13; i < 16; i++) row(i, 50, 120, 162, 400, 0, -1, 0, 50, 400, 1);
    tbl[15].e_l = 162;
    for (int i = 16; i < 24; i++) row(i, 200, 290, -1, -1, 0, -1, 0, 162, 400, 1);
    row(23, 200, 290, -1, -1, 0, -1, 0, 0, 0, 0);
    row(24, 300, 479, -1, -1, 0, -1, 0, 0, 0, 0);
    row(25, 300, 479, -1, -1, 0, -1, 0, 0, 0, 0);
    row(26, 300, 479, -1, -1, 0, -1, 0, 300, 479, 1);
    row(27, 0, 150, -1, -1, 0, -1, 0, 300, 479, 1);
    row(28, 100, 479, -1, -1, 0, 300, 0, 300, 479, 1);
    row(29, 100, 479, -1, -1, 0, 300, 0, 300, 479, 1);
    row(30, 100, 479, -1, -1, 0, 300, 0, 100, 299, 1);
    row(31, -1, -1, -1, -1, 0, -1, 1, 100, 299, 1);
    row(32, 200, 300, -1, -1, 0, -1, 0, 100, 299, 1);
    row(33, 200, 300, -1, -1, 0, -1, 0, 100, 299, 1);
    row(34, 200, 300, -1, -1, 0, -1, 0, 200, 300, 1);

    rst_n = 1'b0; in_vs = 1'b1; in_de = 1'b0; in_data = 1'b0; x_in = '0; y_in = '0;
    model_reset();
    repeat (3) step();
    check("reset_left", bar_left, 0);
    check("reset_right", bar_right, 0);
    check("reset_valid", bar_valid, 0);
    check("reset_fd", frame_done, 0);
    rst_n = 1'b1;
    repeat (3) step();

    foreach (tbl[i]) begin
      clear_line();
      if (tbl[i].a_l >= 0) paint(tbl[i].a_l, tbl[i].a_r, 1'b1);
      if (tbl[i].hole > 0) begin
        mid = (tbl[i].a_l + tbl[i].a_r) / 2;
        paint(mid - tbl[i].hole / 2, mid - tbl[i].hole / 2 + tbl[i].hole - 1, 1'b0);
      end
      if (tbl[i].b_l >= 0) paint(tbl[i].b_l, tbl[i].b_r, 1'b1);
      run_frame(tbl[i].trunc, -1, tbl[i].skip);
      check($sformatf("tbl%0d_left", i), bar_left, tbl[i].e_l);
      check($sformatf("tbl%0d_right", i), bar_right, tbl[i].e_r);
      check($sformatf("tbl%0d_valid", i), bar_valid, tbl[i].e_v);
    end

    for (int s = 0; s < 8; s++) begin
      bl = $urandom_range(0, 300);
      j = $urandom_range(60, 179);
      br = bl + j;
      if (br > W - 1) br = W - 1;
      reps = $urandom_range(2, 5);
      kind = $urandom_range(0, 5);
      for (int rp = 0; rp < reps; rp++) begin
        clear_line();
        j = $urandom_range(0, 12); jl = bl + j - 6; if (jl < 0) jl = 0;
        j = $urandom_range(0, 12); jr = br + j - 6; if (jr > W - 1) jr = W - 1;
        paint(jl, jr, 1'b1);
        if (kind == 1) begin
          hl = $urandom_range(1, 60);
          j = $urandom_range(0, 40);
          paint(jl + 5 + j, jl + 4 + j + hl, 1'b0);
        end
        if (kind == 2) begin
          j = $urandom_range(0, 470);
          hl = $urandom_range(0, 8);
          paint(j, j + hl, 1'b1);
        end
        trunc = (kind == 3) ? int'($urandom_range(20, W - 1)) : -1;
        skip = (kind == 4) && (rp == 1);
        run_frame(trunc, -1, skip);
      end
    end

    clear_line();
    paint(150, 330, 1'b1);
    run_frame(-1, 200, 1'b0);
    check("post_rst_valid", bar_valid, 0);
    run_frame(-1, -1, 1'b0);
    run_frame(-1, -1, 1'b0);
    check("relock_2nd_valid", bar_valid, 0);
    run_frame(-1, -1, 1'b0);
    check("relock_left", bar_left, 150);
    check("relock_right", bar_right, 330);
    check("relock_valid", bar_valid, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
